// File: rtl/decoder_pkg.sv
// Shared types, mode constants and the active-low one-hot decode helper for decoder_scan.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIRECT     = 2'd1,
    SCAN_ON    = 2'd2,
    SCAN_BLANK = 2'd3
  } dec_state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest decode supported; callers truncate to their own output width.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 256;

  function automatic logic [MAX_OUT_W-1:0] onehot_n(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_OUT_W-1:0] one_v;
    one_v    = '0;
    one_v[0] = 1'b1;
    return ~(one_v << sel);
  endfunction

endpackage

// File: rtl/dec_next_sel.sv
// Combinational scan advance: next channel index and wrap flag.
// With DECODER_SCAN_SKIP_EN defined, masked channels are skipped and found reports whether any channel is eligible.
module dec_next_sel #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [SEL_W-1:0]        last,
`ifdef DECODER_SCAN_SKIP_EN
  input  logic [(1<<SEL_W)-1:0]   skip_mask,
`endif
  output logic [SEL_W-1:0]        next_sel,
  output logic                    wrap,
  output logic                    found
);

`ifdef DECODER_SCAN_SKIP_EN
  logic [SEL_W-1:0] hi_idx_s;
  logic [SEL_W-1:0] lo_idx_s;
  logic             hi_ok_s;
  logic             lo_ok_s;

  // Descending search so the smallest eligible index wins, both above sel and overall
  always_comb begin
    hi_idx_s = '0;
    lo_idx_s = '0;
    hi_ok_s  = 1'b0;
    lo_ok_s  = 1'b0;
    for (int i = (1 << SEL_W) - 1; i >= 0; i--) begin
      if ((SEL_W'(i) <= last) && !skip_mask[i]) begin
        lo_idx_s = SEL_W'(i);
        lo_ok_s  = 1'b1;
        if (SEL_W'(i) > sel) begin
          hi_idx_s = SEL_W'(i);
          hi_ok_s  = 1'b1;
        end else begin
          hi_idx_s = hi_idx_s;
        end
      end else begin
        lo_ok_s = lo_ok_s;
      end
    end
  end

  // Prefer the next index above sel; falling back to the lowest one is a wrap
  always_comb begin
    if (hi_ok_s) begin
      next_sel = hi_idx_s;
      wrap     = 1'b0;
      found    = 1'b1;
    end else if (lo_ok_s) begin
      next_sel = lo_idx_s;
      wrap     = 1'b1;
      found    = 1'b1;
    end else begin
      next_sel = sel;
      wrap     = 1'b0;
      found    = 1'b0;
    end
  end
`else
  // Plain increment, wrapping once sel reaches or passes last
  always_comb begin
    found = 1'b1;
    if (sel >= last) begin
      next_sel = '0;
      wrap     = 1'b1;
    end else begin
      next_sel = sel + SEL_W'(1);
      wrap     = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/decoder_scan.sv
// Registered, parametrised active-low decoder with direct-load and autonomous scan modes.
// Optional DECODER_SCAN_SKIP_EN adds skip_mask_i to leave channels out of the scan.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int  SEL_W     = 3,
  parameter int  DWELL_W   = 8,
  parameter int  BLANK_CYC = 1,
  localparam int OUT_W     = 1 << SEL_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               g1_en_i,
  input  logic               g2a_en_n_i,
  input  logic               g2b_en_n_i,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               sel_load_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [SEL_W-1:0]   last_i,
`ifdef DECODER_SCAN_SKIP_EN
  input  logic [OUT_W-1:0]   skip_mask_i,
`endif
  output logic [OUT_W-1:0]   yn_o,
  output logic [SEL_W-1:0]   cur_sel_o,
  output logic               wrap_o
);

  localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  dec_state_e         state_r, state_s;
  logic [SEL_W-1:0]   sel_r, sel_s;
  logic [DWELL_W-1:0] dwell_r, dwell_s;
  logic [BLANK_W-1:0] blank_r, blank_s;
  logic [OUT_W-1:0]   yn_r, yn_s;
  logic               wrap_r, wrap_s;
  logic               en_s;
  logic               blank_done_s;
  logic [SEL_W-1:0]   adv_sel_s;
  logic               adv_wrap_s;
  logic               adv_found_s;

  assign en_s         = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i;
  assign blank_done_s = (BLANK_CYC < 32'sd1) || ((int'(blank_r) + 32'sd1) >= BLANK_CYC);

  dec_next_sel #(
    .SEL_W     (SEL_W)
  ) u_next_sel (
    .sel       (sel_r),
    .last      (last_i),
`ifdef DECODER_SCAN_SKIP_EN
    .skip_mask (skip_mask_i),
`endif
    .next_sel  (adv_sel_s),
    .wrap      (adv_wrap_s),
    .found     (adv_found_s)
  );

  // Next-state, next-select and counter logic
  always_comb begin
    state_s = state_r;
    sel_s   = sel_r;
    dwell_s = dwell_r;
    blank_s = blank_r;
    wrap_s  = 1'b0;
    if (!en_s) begin
      state_s = IDLE;
      dwell_s = '0;
      blank_s = '0;
    end else begin
      case (state_r)
        IDLE, DIRECT: begin
          if (mode_i == MODE_SCAN) begin
            state_s = SCAN_ON;
            sel_s   = '0;
            dwell_s = '0;
            blank_s = '0;
          end else begin
            state_s = DIRECT;
            sel_s   = ((state_r == DIRECT) && sel_load_i) ? sel_i : sel_r;
          end
        end
        SCAN_ON: begin
          if (mode_i == MODE_DIRECT) begin
            state_s = DIRECT;
          end else if (dwell_r >= dwell_i) begin
            dwell_s = '0;
            // With no blanking the advance happens here; an empty scan set still parks in blank
            if (BLANK_CYC > 0) begin
              state_s = SCAN_BLANK;
              blank_s = '0;
            end else if (adv_found_s) begin
              sel_s  = adv_sel_s;
              wrap_s = adv_wrap_s;
            end else begin
              state_s = SCAN_BLANK;
              blank_s = '0;
            end
          end else begin
            dwell_s = dwell_r + DWELL_W'(1);
          end
        end
        SCAN_BLANK: begin
          if (mode_i == MODE_DIRECT) begin
            state_s = DIRECT;
            blank_s = '0;
          end else if (blank_done_s) begin
            if (adv_found_s) begin
              state_s = SCAN_ON;
              sel_s   = adv_sel_s;
              wrap_s  = adv_wrap_s;
              blank_s = '0;
              dwell_s = '0;
            end else begin
              state_s = SCAN_BLANK;
            end
          end else begin
            blank_s = blank_r + BLANK_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs line up with the registered state
  always_comb begin
    if ((state_s == DIRECT) || (state_s == SCAN_ON)) begin
      yn_s = OUT_W'(onehot_n(MAX_SEL_W'(sel_s)));
    end else begin
      yn_s = '1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      sel_r   <= '0;
      dwell_r <= '0;
      blank_r <= '0;
      yn_r    <= '1;
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      dwell_r <= dwell_s;
      blank_r <= blank_s;
      yn_r    <= yn_s;
      wrap_r  <= wrap_s;
    end
  end

  assign yn_o      = yn_r;
  assign cur_sel_o = sel_r;
  assign wrap_o    = wrap_r;

endmodule
